keypad_scanner_param: RTL and testbench

- Parametrised matrix-keypad scanner; successor to the fixed 4x4 scanner.
- Drives one row at a time, samples synchronised columns, and debounces press and release with a tick counter.
- Encodes the pressed key as a linear index and delivers each press once over a valid/ready handshake.
- Sits between the keypad pins and the key-consuming logic (display/seven-segment path). Rejects multi-key presses and flags overrun.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_scanner_param_if.sv | 11 +
 rtl/tick_divider.sv | 24 ++
 rtl/keypad_scanner_param.sv | 166 ++++++++++++++++
 tb/tb_keypad_scanner_param.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the parametrised keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, CONFIRM, HELD, RELEASE} state_t;

  // Column vectors are zero-extended to this width before decoding.
  localparam int unsigned MAX_COLS = 8;

  function automatic logic [2:0] onehot_to_index(input logic [MAX_COLS-1:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_COLS; i++) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic popcount_gt1(input logic [MAX_COLS-1:0] vec);
    return (vec & (vec - 8'd1)) != '0;
  endfunction

endpackage

// File: rtl/keypad_scanner_param_if.sv
// Key delivery channel: code plus valid/ready handshake.
interface keypad_scanner_param_if #(
    parameter int unsigned CODE_W = 4
);
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/tick_divider.sv
// Free-running divider producing a one-clk tick every DIV cycles.
module tick_divider #(
    parameter int unsigned DIV = 65536
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/keypad_scanner_param.sv
// Row-scanning keypad front end with press/release debounce and a
// one-shot valid/ready key channel.
module keypad_scanner_param import keypad_pkg::*; #(
    parameter int unsigned NUM_ROWS       = 4,
    parameter int unsigned NUM_COLS       = 4,
    parameter int unsigned SCAN_DIV       = 65536,
    parameter int unsigned DEBOUNCE_TICKS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row_n,
    output logic                key_held,
    output logic                multi_key,
    output logic                overrun,
    keypad_scanner_param_if.master key_if
);
    localparam int unsigned CODE_W = $clog2(NUM_ROWS * NUM_COLS);
    localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [7:0]  DEB    = 8'(DEBOUNCE_TICKS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    logic                tick;
    logic [NUM_COLS-1:0] col_meta_q, col_sync_q;
    logic [MAX_COLS-1:0] low;
    logic                hit, multi, idle;
    logic [2:0]          hit_idx;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d, row_next;
    logic [7:0]          cnt_q, cnt_d;
    logic [2:0]          cand_q, cand_d;
    logic                accept, xfer;
    logic [CODE_W-1:0]   key_code_q, key_code_d, new_code;
    logic                key_valid_q, key_valid_d;
    logic                overrun_q, overrun_d;

    tick_divider #(.DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        low = '0;
        low[NUM_COLS-1:0] = ~col_sync_q;
        multi    = popcount_gt1(low);
        idle     = (low == '0);
        hit      = !idle && !multi;
        hit_idx  = onehot_to_index(low);
        row_next = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            state_q     <= SCAN;
            row_q       <= '0;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            col_meta_q  <= col_n;
            col_sync_q  <= col_meta_q;
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Scan/debounce decisions happen only on tick; between ticks everything holds.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (hit) begin
                        cand_d = hit_idx;
                        cnt_d  = 8'd1;
                        if (DEB == 8'd1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end else begin
                        row_d = row_next;
                    end
                end
                CONFIRM: begin
                    if (hit && (hit_idx == cand_q)) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == DEB) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                        row_d   = row_next;
                    end
                end
                HELD: begin
                    if (idle) begin
                        cnt_d = 8'd1;
                        if (DEB == 8'd1) begin
                            state_d = SCAN;
                            row_d   = row_next;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (idle) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == DEB) begin
                            state_d = SCAN;
                            row_d   = row_next;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // A press landing on a still-full slot keeps the old code and flags overrun.
    always_comb begin
        new_code    = CODE_W'(row_q) * CODE_W'(NUM_COLS) + CODE_W'(cand_d);
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        xfer        = key_valid_q && key_if.key_ready;
        if (xfer) key_valid_d = 1'b0;
        if (accept) begin
            if (!key_valid_q || xfer) begin
                key_code_d  = new_code;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        row_n            = ~(NUM_ROWS'(1) << row_q);
        key_held         = (state_q == HELD) || (state_q == RELEASE);
        multi_key        = tick && (state_q == SCAN) && multi;
        overrun          = overrun_q;
        key_if.key_code  = key_code_q;
        key_if.key_valid = key_valid_q;
    end
endmodule

// File: tb/tb_keypad_scanner_param.sv
// Bench: 4x4 scanner against a tick-level reference model, plus a 3x5 sweep.
module tb_keypad_scanner_param;
    localparam int unsigned AR = 4, AC = 4, ADIV = 8, ADEB = 3;
    localparam int unsigned BR = 3, BC = 5, BDIV = 4, BDEB = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [AR-1:0][AC-1:0] press_a = '0;
    logic [BR-1:0][BC-1:0] press_b = '0;
    logic [AC-1:0] col_n_a;
    logic [AR-1:0] row_n_a;
    logic [BC-1:0] col_n_b;
    logic [BR-1:0] row_n_b;
    logic held_a, multi_a, ovr_a, held_b, multi_b, ovr_b;

    keypad_scanner_param_if #(.CODE_W(4)) if_a ();
    keypad_scanner_param_if #(.CODE_W(4)) if_b ();

    keypad_scanner_param #(.NUM_ROWS(AR), .NUM_COLS(AC), .SCAN_DIV(ADIV),
                           .DEBOUNCE_TICKS(ADEB)) dut_a (
        .clk(clk), .reset(reset), .col_n(col_n_a), .row_n(row_n_a), .key_held(held_a),
        .multi_key(multi_a), .overrun(ovr_a), .key_if(if_a));

    keypad_scanner_param #(.NUM_ROWS(BR), .NUM_COLS(BC), .SCAN_DIV(BDIV),
                           .DEBOUNCE_TICKS(BDEB)) dut_b (
        .clk(clk), .reset(reset), .col_n(col_n_b), .row_n(row_n_b), .key_held(held_b),
        .multi_key(multi_b), .overrun(ovr_b), .key_if(if_b));

    // Physical matrix: a pressed switch pulls its column low while its row is driven.
    always_comb begin
        col_n_a = '1;
        for (int r = 0; r < AR; r++)
            for (int c = 0; c < AC; c++)
                if (press_a[r][c] && !row_n_a[r]) col_n_a[c] = 1'b0;
        col_n_b = '1;
        for (int r = 0; r < BR; r++)
            for (int c = 0; c < BC; c++)
                if (press_b[r][c] && !row_n_b[r]) col_n_b[c] = 1'b0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which row is scanned, how long the current observation has
    // persisted, whether a key is considered down, and the one-entry output slot.
    int   m_cnt = 0, m_row = 0, m_streak = 0, m_col = 0;
    bit   m_down = 0, m_valid = 0, m_ovr = 0;
    logic [3:0] m_code = '0;

    initial forever begin
        bit t, emit;
        int n, c;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_cnt = 0; m_row = 0; m_streak = 0; m_col = 0;
            m_down = 0; m_valid = 0; m_ovr = 0; m_code = '0;
        end else begin
            t = (m_cnt == ADIV - 1);
            m_cnt = t ? 0 : m_cnt + 1;
            emit = 0;
            if (t) begin
                n = 0; c = 0;
                for (int k = 0; k < AC; k++) if (press_a[m_row][k]) begin n++; c = k; end
                if (!m_down) begin
                    if (n == 1 && (m_streak == 0 || c == m_col)) begin
                        m_col = c;
                        m_streak++;
                        if (m_streak == ADEB) begin emit = 1; m_down = 1; m_streak = 0; end
                    end else begin
                        m_streak = 0;
                        m_row = (m_row + 1) % AR;
                    end
                end else if (n == 0) begin
                    m_streak++;
                    if (m_streak == ADEB) begin
                        m_down = 0; m_streak = 0; m_row = (m_row + 1) % AR;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            if (emit) begin
                if (!m_valid || if_a.key_ready) begin
                    m_code = 4'(m_row * AC + m_col);
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && if_a.key_ready) begin
                m_valid = 0;
            end
        end
    end

    initial forever begin
        logic [AR-1:0] exp_row;
        int n;
        @(negedge clk);
        if (!reset) begin
            exp_row = '1;
            exp_row[m_row] = 1'b0;
            n = 0;
            for (int k = 0; k < AC; k++) if (press_a[m_row][k]) n++;
            check("m_row_n", row_n_a, exp_row);
            check("m_key_valid", if_a.key_valid, m_valid);
            if (m_valid) check("m_key_code", if_a.key_code, m_code);
            check("m_key_held", held_a, m_down);
            check("m_multi_key", multi_a,
                  (m_cnt == ADIV - 1) && !m_down && (m_streak == 0) && (n > 1));
            check("m_overrun", ovr_a, m_ovr);
        end
    end

    // Step to the falling edge just after the next tick of dut_a.
    task automatic align();
        do @(negedge clk); while (m_cnt != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) align();
    endtask

    task automatic wait_valid_a(input int max_ticks, input string nm);
        int k = 0;
        while (!if_a.key_valid && k < max_ticks * ADIV) begin @(negedge clk); k++; end
        check(nm, if_a.key_valid, 1);
    endtask

    task automatic wait_held_a(input bit lvl, input int max_ticks, input string nm);
        int k = 0;
        while (held_a !== lvl && k < max_ticks * ADIV) begin @(negedge clk); k++; end
        check(nm, held_a, lvl);
    endtask

    task automatic ack_a();
        if_a.key_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", if_a.key_valid, 0);
        if_a.key_ready = 1'b0;
    endtask

    typedef struct {int row; int col; logic [3:0] code; int hold;} press_vec_t;
    press_vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] arow[4];
        logic [2:0] brow[3];
        int cnt, kind, r, r2, c, c2, hold;

        vecs[0] = '{2, 1, 4'd9, 20};
        vecs[1] = '{0, 0, 4'd0, 1};
        vecs[2] = '{3, 3, 4'd15, 2};
        vecs[3] = '{1, 2, 4'd6, 1};
        vecs[4] = '{0, 3, 4'd3, 4};
        arow = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        brow = '{3'b110, 3'b101, 3'b011};
        if_a.key_ready = 1'b0;
        if_b.key_ready = 1'b0;

        // Reset values and free-running row rotation on both sizes.
        repeat (3) @(negedge clk);
        check("rst_row_n", row_n_a, 4'b1110);
        check("rst_row_n_b", row_n_b, 3'b110);
        check("rst_valid", if_a.key_valid, 0);
        check("rst_code", if_a.key_code, 0);
        check("rst_held", held_a, 0);
        check("rst_multi", multi_a, 0);
        check("rst_overrun", ovr_a, 0);
        #2 reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            repeat (BDIV) @(posedge clk);
            @(negedge clk);
            check("scan_row_b", row_n_b, brow[k % 3]);
            if (k % 2 == 0) check("scan_row_a", row_n_a, arow[(k / 2) % 4]);
        end

        // Clean presses from a table, each acknowledged, held, then released.
        for (int i = 0; i < 5; i++) begin
            align();
            press_a[vecs[i].row][vecs[i].col] = 1'b1;
            wait_valid_a(20, "press_valid");
            check("press_code", if_a.key_code, vecs[i].code);
            ack_a();
            for (int h = 0; h < vecs[i].hold; h++) begin
                align();
                check("hold_no_repeat", if_a.key_valid, 0);
                check("hold_held", held_a, 1);
            end
            align();
            press_a = '0;
            wait_held_a(0, 10, "release_held");
        end

        // Press bounce on row 0, col 3: never reaches the debounce count.
        align();
        for (int k = 0; k < 8 && m_row != 0; k++) align();
        press_a[0][3] = 1'b1; ticks(2);
        press_a = '0;         ticks(1);
        press_a[0][3] = 1'b1; ticks(2);
        press_a = '0;         ticks(4);
        check("bounce_valid", if_a.key_valid, 0);
        check("bounce_held", held_a, 0);

        // Release bounce shorter than the debounce keeps the key down.
        align();
        press_a[3][0] = 1'b1;
        wait_valid_a(20, "rb_valid");
        ack_a();
        align();
        press_a = '0;
        ticks(2);
        check("rb_held_gap", held_a, 1);
        press_a[3][0] = 1'b1;
        for (int k = 0; k < 3; k++) begin align(); check("rb_held", held_a, 1); end
        press_a = '0;
        wait_held_a(0, 10, "rb_release");
        check("rb_no_second", if_a.key_valid, 0);

        // Two columns in row 1: one multi_key pulse per visit, no key.
        align();
        press_a[1][0] = 1'b1;
        press_a[1][2] = 1'b1;
        cnt = 0;
        repeat (8 * ADIV) begin @(negedge clk); if (multi_a) cnt++; end
        check("multi_count", cnt, 2);
        check("multi_valid", if_a.key_valid, 0);
        press_a = '0;

        // Overrun: second press while the first is still unconsumed.
        align();
        press_a[1][1] = 1'b1;
        wait_valid_a(20, "ovr_first");
        align();
        press_a = '0;
        wait_held_a(0, 10, "ovr_rel1");
        align();
        press_a[2][2] = 1'b1;
        wait_held_a(1, 20, "ovr_held2");
        check("ovr_code", if_a.key_code, 5);
        check("ovr_valid", if_a.key_valid, 1);
        check("ovr_flag", ovr_a, 1);
        ack_a();
        check("ovr_after_xfer", ovr_a, 1);
        align();
        press_a = '0;
        wait_held_a(0, 10, "ovr_rel2");
        check("ovr_sticky", ovr_a, 1);

        // 3x5 instance: row 2, col 4 encodes to 14.
        align();
        press_b[2][4] = 1'b1;
        cnt = 0;
        while (!if_b.key_valid && cnt < 40 * BDIV) begin @(negedge clk); cnt++; end
        check("sweep_valid", if_b.key_valid, 1);
        check("sweep_code", if_b.key_code, 14);
        check("sweep_held", held_b, 1);
        if_b.key_ready = 1'b1;
        @(negedge clk);
        check("sweep_drop", if_b.key_valid, 0);
        if_b.key_ready = 1'b0;
        align();
        press_b = '0;

        // Asynchronous reset mid-dwell drops a pending key and the overrun flag.
        align();
        press_a[0][1] = 1'b1;
        wait_valid_a(20, "pre_reset_valid");
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_row_n", row_n_a, 4'b1110);
        check("mid_rst_valid", if_a.key_valid, 0);
        check("mid_rst_overrun", ovr_a, 0);
        check("mid_rst_held", held_a, 0);
        press_a = '0;
        @(negedge clk);
        #2 reset = 1'b0;

        // Random key patterns and consumer back-pressure against the model.
        for (int s = 0; s < 60; s++) begin
            align();
            kind = $urandom_range(0, 3);
            r  = $urandom_range(0, AR - 1);
            c  = $urandom_range(0, AC - 1);
            r2 = (r + 1 + $urandom_range(0, AR - 2)) % AR;
            c2 = (c + 1 + $urandom_range(0, AC - 2)) % AC;
            press_a = '0;
            case (kind)
                1: press_a[r][c] = 1'b1;
                2: begin press_a[r][c] = 1'b1; press_a[r][c2] = 1'b1; end
                3: begin press_a[r][c] = 1'b1; press_a[r2][c2] = 1'b1; end
                default: ;
            endcase
            hold = $urandom_range(1, 12);
            for (int t = 0; t < hold; t++) begin
                do begin
                    @(negedge clk);
                    if_a.key_ready = ($urandom_range(0, 3) != 0);
                end while (m_cnt != 0);
            end
        end
        press_a = '0;
        if_a.key_ready = 1'b1;
        ticks(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
